// File: rtl/gbt_link_sequencer.sv
// gbt_link_sequencer: brings up the SFP/GBT link and supervises it while up.
// It enables the SFP transmitter, holds the GBT core in reset until the optical
// signal is present, then waits for tx/rx/link ready with a timeout. Loss of
// signal or a ready drop while up re-runs the bring-up, with bounded retries
// before lockout.
//
//   state   | code | meaning
//   --------+------+---------------------------------------------------------
//   OFF     |  0   | transmitter off, core in reset, retry count cleared
//   TXEN    |  1   | transmitter on, core in reset, fixed settle dwell
//   WAITLOS |  2   | waiting for the synchronised LOS to go low
//   WAITRDY |  3   | core released, waiting for all ready flags (timeout)
//   UP      |  4   | link up, watching ready flags and debounced LOS
//   FAIL    |  5   | one-cycle failure bookkeeping, then retry or lockout
//   LOCKOUT |  6   | too many failures; only dropping enable leaves

package gbt_link_sequencer_pkg;
    typedef struct packed {
        logic clk;
        logic reset;
    } ckrs_t;
endpackage

module gbt_link_sequencer
    import gbt_link_sequencer_pkg::*;
#(
    parameter int unsigned g_TxEnWait     = 1024,
    parameter int unsigned g_ReadyTimeout = 1_200_000,
    parameter int unsigned g_LosDebounce  = 64,
    parameter int unsigned g_MaxRetries   = 8,
    parameter logic        g_RateSelect   = 1'b1
) (
    input  ckrs_t      ClkRs_ix,
    input  logic       enable_i,
    input  logic       force_reset_i,
    input  logic       sfp_los_i,
    input  logic       tx_ready_i,
    input  logic       rx_ready_i,
    input  logic       link_ready_i,
    output logic       sfp_txdisable_o,
    output logic       sfp_rateselect_o,
    output logic       gbt_reset_o,
    output logic       link_up_o,
    output logic       error_o,
    output logic [2:0] state_ob3,
    output logic [7:0] retry_count_ob8
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_TXEN    = 3'd1,
        ST_WAITLOS = 3'd2,
        ST_WAITRDY = 3'd3,
        ST_UP      = 3'd4,
        ST_FAIL    = 3'd5,
        ST_LOCKOUT = 3'd6
    } state_t;

    localparam int TX_W  = $clog2(g_TxEnWait) + 1;
    localparam int RDY_W = $clog2(g_ReadyTimeout) + 1;
    localparam int LOS_W = $clog2(g_LosDebounce) + 1;

    // Down-counters load "dwell - 1" on entry so terminal count is zero.
    localparam logic [TX_W-1:0]  TX_LOAD  = TX_W'(g_TxEnWait - 1);
    localparam logic [RDY_W-1:0] RDY_LOAD = RDY_W'(g_ReadyTimeout - 1);
    localparam logic [LOS_W-1:0] LOS_LOAD = LOS_W'(g_LosDebounce - 1);

    state_t           state_q, state_d;
    logic             los_meta_q, los_s_q;
    logic [TX_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [RDY_W-1:0] rdy_cnt_q, rdy_cnt_d;
    logic [LOS_W-1:0] los_cnt_q, los_cnt_d;
    logic [7:0]       retry_q, retry_d;
    logic             txdisable_q, txdisable_d;
    logic             gbt_reset_q, gbt_reset_d;
    logic             link_up_q, link_up_d;
    logic             error_q, error_d;
    logic             restart;
    logic             entering;
    logic             all_ready;
    logic             retry_allowed;

    assign all_ready     = tx_ready_i & rx_ready_i & link_ready_i;
    // retry_q already holds the incremented count while in FAIL.
    assign retry_allowed = (g_MaxRetries == 0) || ({24'd0, retry_q} < g_MaxRetries);

    // Two-flop synchroniser for the asynchronous LOS pin; resets to "signal lost".
    always_ff @(posedge ClkRs_ix.clk) begin
        if (ClkRs_ix.reset) begin
            los_meta_q <= 1'b1;
            los_s_q    <= 1'b1;
        end else begin
            los_meta_q <= sfp_los_i;
            los_s_q    <= los_meta_q;
        end
    end

    // Next-state decision: disable beats forced restart beats normal flow.
    always_comb begin
        state_d = state_q;
        restart = 1'b0;
        if (!enable_i) begin
            state_d = ST_OFF;
        end else if (force_reset_i && (state_q != ST_OFF) && (state_q != ST_LOCKOUT)) begin
            state_d = ST_TXEN;
            restart = 1'b1;
        end else begin
            case (state_q)
                ST_OFF:     state_d = ST_TXEN;
                ST_TXEN:    if (tx_cnt_q == '0) state_d = ST_WAITLOS;
                ST_WAITLOS: if (!los_s_q) state_d = ST_WAITRDY;
                ST_WAITRDY: begin
                    if (all_ready)
                        state_d = ST_UP;
                    else if (rdy_cnt_q == '0)
                        state_d = ST_FAIL;
                end
                ST_UP: begin
                    if (!all_ready)
                        state_d = ST_FAIL;
                    else if (los_s_q && (los_cnt_q == '0))
                        state_d = ST_FAIL;
                end
                ST_FAIL:    state_d = retry_allowed ? ST_TXEN : ST_LOCKOUT;
                ST_LOCKOUT: state_d = ST_LOCKOUT;
                default:    state_d = ST_OFF;
            endcase
        end
    end

    // Counter, retry and output values for the state being entered.
    always_comb begin
        entering    = restart || (state_d != state_q);
        tx_cnt_d    = tx_cnt_q;
        rdy_cnt_d   = rdy_cnt_q;
        los_cnt_d   = los_cnt_q;
        retry_d     = retry_q;
        txdisable_d = 1'b1;
        gbt_reset_d = 1'b1;
        link_up_d   = 1'b0;
        error_d     = 1'b0;

        if (entering && (state_d == ST_TXEN))
            tx_cnt_d = TX_LOAD;
        else if ((state_q == ST_TXEN) && (tx_cnt_q != '0))
            tx_cnt_d = tx_cnt_q - TX_W'(1);

        if (entering && (state_d == ST_WAITRDY))
            rdy_cnt_d = RDY_LOAD;
        else if ((state_q == ST_WAITRDY) && (rdy_cnt_q != '0))
            rdy_cnt_d = rdy_cnt_q - RDY_W'(1);

        // Debounce run restarts on any low LOS sample.
        if (entering && (state_d == ST_UP))
            los_cnt_d = LOS_LOAD;
        else if (state_q == ST_UP) begin
            if (!los_s_q)
                los_cnt_d = LOS_LOAD;
            else if (los_cnt_q != '0)
                los_cnt_d = los_cnt_q - LOS_W'(1);
        end

        // The count is visible as incremented during the FAIL cycle itself.
        if (state_d == ST_OFF)
            retry_d = 8'd0;
        else if (entering && (state_d == ST_FAIL) && (retry_q != 8'hFF))
            retry_d = retry_q + 8'd1;

        case (state_d)
            ST_TXEN, ST_WAITLOS, ST_FAIL: txdisable_d = 1'b0;
            ST_WAITRDY: begin
                txdisable_d = 1'b0;
                gbt_reset_d = 1'b0;
            end
            ST_UP: begin
                txdisable_d = 1'b0;
                gbt_reset_d = 1'b0;
                link_up_d   = 1'b1;
            end
            ST_LOCKOUT: error_d = 1'b1;
            default: ;
        endcase
    end

    // State, counters and registered Moore outputs.
    always_ff @(posedge ClkRs_ix.clk) begin
        if (ClkRs_ix.reset) begin
            state_q     <= ST_OFF;
            tx_cnt_q    <= TX_LOAD;
            rdy_cnt_q   <= RDY_LOAD;
            los_cnt_q   <= LOS_LOAD;
            retry_q     <= 8'd0;
            txdisable_q <= 1'b1;
            gbt_reset_q <= 1'b1;
            link_up_q   <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_cnt_q    <= tx_cnt_d;
            rdy_cnt_q   <= rdy_cnt_d;
            los_cnt_q   <= los_cnt_d;
            retry_q     <= retry_d;
            txdisable_q <= txdisable_d;
            gbt_reset_q <= gbt_reset_d;
            link_up_q   <= link_up_d;
            error_q     <= error_d;
        end
    end

    assign sfp_txdisable_o  = txdisable_q;
    assign sfp_rateselect_o = g_RateSelect;
    assign gbt_reset_o      = gbt_reset_q;
    assign link_up_o        = link_up_q;
    assign error_o          = error_q;
    assign state_ob3        = state_q;
    assign retry_count_ob8  = retry_q;

endmodule

// File: tb/tb_gbt_link_sequencer.sv
// Testbench for gbt_link_sequencer: directed bring-up scenarios followed by a
// randomized run, every cycle compared against a dwell-time reference model.
module tb_gbt_link_sequencer;
    import gbt_link_sequencer_pkg::*;

    localparam int TXW = 16;
    localparam int RT  = 100;
    localparam int LD  = 8;
    localparam int MR  = 3;

    localparam int M_OFF = 0, M_TXEN = 1, M_WAITLOS = 2, M_WAITRDY = 3,
                   M_UP = 4, M_FAIL = 5, M_LOCKOUT = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    ckrs_t clkrs;
    assign clkrs = '{clk: clk, reset: rst};

    logic enable = 1'b0, force_rst = 1'b0, los = 1'b0;
    logic tx_rdy = 1'b0, rx_rdy = 1'b0, lk_rdy = 1'b0;
    logic txdis, ratesel, grst, link_up, err;
    logic [2:0] state;
    logic [7:0] retry;

    always #5 clk = ~clk;

    gbt_link_sequencer #(
        .g_TxEnWait    (TXW),
        .g_ReadyTimeout(RT),
        .g_LosDebounce (LD),
        .g_MaxRetries  (MR),
        .g_RateSelect  (1'b1)
    ) dut (
        .ClkRs_ix        (clkrs),
        .enable_i        (enable),
        .force_reset_i   (force_rst),
        .sfp_los_i       (los),
        .tx_ready_i      (tx_rdy),
        .rx_ready_i      (rx_rdy),
        .link_ready_i    (lk_rdy),
        .sfp_txdisable_o (txdis),
        .sfp_rateselect_o(ratesel),
        .gbt_reset_o     (grst),
        .link_up_o       (link_up),
        .error_o         (err),
        .state_ob3       (state),
        .retry_count_ob8 (retry)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: state code, cycles already spent in it, LOS run length.
    int   m_state = 0, m_dwell = 0, m_los_run = 0, m_retry = 0;
    logic m_sync1 = 1'b1, m_sync2 = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_edge();
        logic los_s;
        bit   rdy, restart;
        int   ns;
        los_s = m_sync2;
        if (rst) begin
            m_state = M_OFF; m_dwell = 0; m_los_run = 0; m_retry = 0;
            m_sync1 = 1'b1; m_sync2 = 1'b1;
            return;
        end
        rdy     = tx_rdy && rx_rdy && lk_rdy;
        restart = enable && force_rst && m_state != M_OFF && m_state != M_LOCKOUT;
        ns = m_state;
        if (!enable) ns = M_OFF;
        else if (restart) ns = M_TXEN;
        else begin
            case (m_state)
                M_OFF:     ns = M_TXEN;
                M_TXEN:    ns = (m_dwell + 1 >= TXW) ? M_WAITLOS : M_TXEN;
                M_WAITLOS: ns = los_s ? M_WAITLOS : M_WAITRDY;
                M_WAITRDY: ns = rdy ? M_UP : ((m_dwell + 1 >= RT) ? M_FAIL : M_WAITRDY);
                M_UP:      ns = (!rdy || (los_s && m_los_run + 1 >= LD)) ? M_FAIL : M_UP;
                M_FAIL:    ns = (MR == 0 || m_retry < MR) ? M_TXEN : M_LOCKOUT;
                default:   ns = M_LOCKOUT;
            endcase
        end
        if (ns == M_OFF) m_retry = 0;
        else if (ns == M_FAIL) m_retry = (m_retry >= 255) ? 255 : m_retry + 1;
        if (ns == M_UP && m_state == M_UP) m_los_run = los_s ? m_los_run + 1 : 0;
        else m_los_run = 0;
        if (ns == m_state && !restart) m_dwell++;
        else m_dwell = 0;
        m_sync2 = m_sync1;
        m_sync1 = los;
        m_state = ns;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        chk("state", state, m_state);
        chk("retry", retry, m_retry);
        chk("txdisable", txdis, (m_state == M_OFF || m_state == M_LOCKOUT));
        chk("gbt_reset", grst, !(m_state == M_WAITRDY || m_state == M_UP));
        chk("link_up", link_up, (m_state == M_UP));
        chk("error", err, (m_state == M_LOCKOUT));
        chk("rateselect", ratesel, 1'b1);
    endtask

    task automatic bring_up();
        los = 1'b0; force_rst = 1'b0;
        tx_rdy = 1'b0; rx_rdy = 1'b0; lk_rdy = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 200 && grst !== 1'b0; i++) step();
        chk("bringup_grst_low", grst, 1'b0);
        tx_rdy = 1'b1; rx_rdy = 1'b1; lk_rdy = 1'b1;
        for (int i = 0; i < 10 && link_up !== 1'b1; i++) step();
        chk("bringup_up", state, M_UP);
    endtask

    initial begin
        int n, t_txdis, nfail;
        logic rdy_ok;

        // Reset values
        repeat (3) step();
        chk("rst_state", state, 0);
        chk("rst_txdis", txdis, 1'b1);
        chk("rst_grst", grst, 1'b1);
        chk("rst_retry", retry, 0);
        rst = 1'b0;
        step();

        // Nominal bring-up
        enable = 1'b1;
        n = 0; t_txdis = -1;
        do begin
            step(); n++;
            if (t_txdis < 0 && txdis === 1'b0) t_txdis = n;
        end while (grst !== 1'b0 && n < 100);
        chk("txdis_after_enable", t_txdis, 1);
        chk("grst_high_cycles", n - 1, TXW + 1);
        n = 0;
        repeat (5) begin step(); n++; end
        tx_rdy = 1'b1; rx_rdy = 1'b1; lk_rdy = 1'b1;
        do begin step(); n++; end while (link_up !== 1'b1 && n < 20);
        chk("linkup_after_grst", n, 6);
        chk("nominal_retry", retry, 0);

        // LOS debounce: 7-cycle burst ignored, 8-cycle burst fails
        los = 1'b1; repeat (7) step();
        los = 1'b0; repeat (5) step();
        chk("los_burst7_ignored", state, M_UP);
        los = 1'b1; n = 0;
        do begin step(); n++; end while (state !== 3'(M_FAIL) && n < 40);
        chk("los_fail_latency", n, LD + 2);
        chk("los_fail_retry", retry, 1);

        // Ready drop in UP
        bring_up();
        rx_rdy = 1'b0; step(); rx_rdy = 1'b1;
        chk("rdydrop_state", state, M_FAIL);
        chk("rdydrop_retry", retry, 2);
        chk("rdydrop_grst", grst, 1'b1);

        // Priority: disable beats force_reset
        bring_up();
        force_rst = 1'b1; enable = 1'b0; step(); force_rst = 1'b0;
        chk("prio_off_state", state, M_OFF);
        chk("prio_off_retry", retry, 0);

        // Priority: force_reset alone keeps retry count
        bring_up();
        rx_rdy = 1'b0; step(); rx_rdy = 1'b1;
        bring_up();
        force_rst = 1'b1; step(); force_rst = 1'b0;
        chk("force_state", state, M_TXEN);
        chk("force_retry", retry, 1);
        chk("force_grst", grst, 1'b1);

        // Timeout to lockout
        enable = 1'b0; step();
        chk("off_before_timeout", state, M_OFF);
        tx_rdy = 1'b0; rx_rdy = 1'b0; lk_rdy = 1'b0; los = 1'b0;
        enable = 1'b1; nfail = 0; n = 0;
        do begin
            step(); n++;
            if (state === 3'(M_FAIL)) begin
                nfail++;
                chk("timeout_fail_retry", retry, nfail);
            end
        end while (state !== 3'(M_LOCKOUT) && n < 600);
        chk("timeout_nfail", nfail, MR);
        chk("lockout_state", state, M_LOCKOUT);
        chk("lockout_error", err, 1'b1);
        chk("lockout_txdis", txdis, 1'b1);
        repeat (5) step();
        chk("lockout_held", state, M_LOCKOUT);
        enable = 1'b0; step();
        chk("unlock_state", state, M_OFF);
        chk("unlock_error", err, 1'b0);
        chk("unlock_retry", retry, 0);

        // Reset in WAITRDY after one timeout failure
        enable = 1'b1; n = 0;
        do begin step(); n++; end while (!(state === 3'(M_WAITRDY) && retry === 8'd1) && n < 300);
        chk("pre_reset_state", state, M_WAITRDY);
        rst = 1'b1; step(); rst = 1'b0;
        chk("midrst_state", state, 0);
        chk("midrst_retry", retry, 0);
        chk("midrst_txdis", txdis, 1'b1);
        chk("midrst_grst", grst, 1'b1);
        chk("midrst_linkup", link_up, 1'b0);
        chk("midrst_error", err, 1'b0);
        step();
        chk("restart_from_off", state, M_TXEN);

        // Randomized run against the model
        rdy_ok = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            force_rst = ($urandom_range(0, 199) == 0);
            rst       = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 19) == 0) los = ~los;
            if ($urandom_range(0, 149) == 0) rdy_ok = ~rdy_ok;
            tx_rdy = rdy_ok && ($urandom_range(0, 199) != 0);
            rx_rdy = rdy_ok && ($urandom_range(0, 199) != 0);
            lk_rdy = rdy_ok && ($urandom_range(0, 199) != 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
